// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: instruction operand/destination info in,
// stall, forwarding selects and the stall performance counter out.
interface hazard_scoreboard_if #(
  parameter int AW    = 5,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [AW-1:0]    id_rs;
  logic [AW-1:0]    id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [AW-1:0]    id_dst;
  logic             id_dst_wr;
  logic             id_is_load;
  logic             flush;
  logic             hold;
  logic             stall;
  logic [SEL_W-1:0] fwd_a_sel;
  logic [SEL_W-1:0] fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_dst, id_dst_wr, id_is_load, flush, hold,
    input  stall, fwd_a_sel, fwd_b_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_dst, id_dst_wr, id_is_load, flush, hold,
    output stall, fwd_a_sel, fwd_b_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Interlock and forwarding controller for the pipelined MIPS core.
// Keeps a shadow copy of the destination registers of the DEPTH stages
// after ID (entry 0 = EX ... entry DEPTH-1 = WR) and derives the load-use
// stall, the ALU operand forwarding selects and a saturating stall counter.
module hazard_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int AW         = 5,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = 2
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave sb
);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] dst;
    logic          wr;
    logic          ld;
  } entry_t;

  entry_t [DEPTH-1:0] board_q;
  entry_t [DEPTH-1:0] board_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [DEPTH-1:0]   matchA;
  logic [DEPTH-1:0]   matchB;
  logic [SEL_W-1:0]   selA;
  logic [SEL_W-1:0]   selB;
  logic               hazA;
  logic               hazB;
  logic               stall;

  // Per-entry producer match for each source operand; $0 never matches
  always_comb begin
    matchA = '0;
    matchB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      matchA[i] = board_q[i].v && board_q[i].wr && sb.id_rs_used &&
                  (board_q[i].dst == sb.id_rs) && (sb.id_rs != '0);
      matchB[i] = board_q[i].v && board_q[i].wr && sb.id_rt_used &&
                  (board_q[i].dst == sb.id_rt) && (sb.id_rt != '0);
    end
  end

  // Walk oldest to youngest so the youngest match sets both select and readiness
  always_comb begin
    selA = '0;
    selB = '0;
    hazA = 1'b0;
    hazB = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (matchA[i]) begin
        selA = SEL_W'(i + 1);
        hazA = board_q[i].ld && (i < LOAD_READY);
      end
      if (matchB[i]) begin
        selB = SEL_W'(i + 1);
        hazB = board_q[i].ld && (i < LOAD_READY);
      end
    end
  end

  // A squashed instruction can never stall the pipe
  assign stall        = sb.id_valid && !sb.flush && (hazA || hazB);
  assign sb.stall     = stall;
  assign sb.fwd_a_sel = selA;
  assign sb.fwd_b_sel = selB;
  assign sb.stall_cnt = cnt_q;

  // Advance the board one stage unless frozen; stalls and flushes inject a bubble
  always_comb begin
    board_d = board_q;
    cnt_d   = cnt_q;
    if (!sb.hold) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        board_d[i] = board_q[i - 1];
      end
      if (stall || sb.flush || !sb.id_valid) begin
        board_d[0] = '0;
      end else begin
        board_d[0] = {1'b1, sb.id_dst, sb.id_dst_wr, sb.id_is_load};
      end
      if (stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset empties the board and clears the counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board_q <= '0;
      cnt_q   <= '0;
    end else begin
      board_q <= board_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-style bench for hazard_scoreboard: each directed vector pushes
// its hand-computed expected outputs into a queue, and a monitor running on
// the falling edge pops and compares them against the DUT.
module tb_hazard_scoreboard;

  localparam int AW    = 5;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  typedef struct {
    string            name;
    logic             stall;
    logic [SEL_W-1:0] fwdA;
    logic [SEL_W-1:0] fwdB;
    logic [CNT_W-1:0] cnt;
  } expect_t;

  logic    clk;
  logic    resetN;
  expect_t expQ[$];
  int      checks;
  int      errors;

  hazard_scoreboard_if #(.AW(AW), .SEL_W(SEL_W), .CNT_W(CNT_W)) busIf ();

  hazard_scoreboard #(
    .DEPTH(3), .AW(AW), .LOAD_READY(2), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk   (clk),
    .reset (resetN),
    .sb    (busIf.slave)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [CNT_W-1:0] sat(input int v);
    return (v > 15) ? 4'd15 : CNT_W'(v);
  endfunction

  // Drive one ID-stage cycle just after the rising edge and queue its expectation
  task automatic applyStimulus(
    input string name, input logic valid,
    input logic [AW-1:0] rs, input logic rsU,
    input logic [AW-1:0] rt, input logic rtU,
    input logic [AW-1:0] dst, input logic dstWr, input logic isLoad,
    input logic fl, input logic hd, input logic rstN,
    input logic expStall, input logic [SEL_W-1:0] expA,
    input logic [SEL_W-1:0] expB, input logic [CNT_W-1:0] expCnt);
    expect_t e;
    @(posedge clk);
    #1;
    busIf.id_valid   = valid;
    busIf.id_rs      = rs;
    busIf.id_rs_used = rsU;
    busIf.id_rt      = rt;
    busIf.id_rt_used = rtU;
    busIf.id_dst     = dst;
    busIf.id_dst_wr  = dstWr;
    busIf.id_is_load = isLoad;
    busIf.flush      = fl;
    busIf.hold       = hd;
    resetN           = rstN;
    e.name  = name;
    e.stall = expStall;
    e.fwdA  = expA;
    e.fwdB  = expB;
    e.cnt   = expCnt;
    expQ.push_back(e);
  endtask

  task automatic idle(input string name, input logic [CNT_W-1:0] expCnt);
    applyStimulus(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, expCnt);
  endtask

  task automatic checkOutput(input expect_t e);
    checks++;
    if (busIf.stall !== e.stall || busIf.fwd_a_sel !== e.fwdA ||
        busIf.fwd_b_sel !== e.fwdB || busIf.stall_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s: got stall=%0b fwdA=%0d fwdB=%0d cnt=%0d, expected stall=%0b fwdA=%0d fwdB=%0d cnt=%0d",
               e.name, busIf.stall, busIf.fwd_a_sel, busIf.fwd_b_sel, busIf.stall_cnt,
               e.stall, e.fwdA, e.fwdB, e.cnt);
    end
  endtask

  // Monitor: compare the oldest pending expectation mid-cycle
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int waitCycles;
    checks = 0;
    errors = 0;
    resetN = 1'b0;
    busIf.id_valid = 0; busIf.id_rs = 0; busIf.id_rs_used = 0;
    busIf.id_rt = 0; busIf.id_rt_used = 0; busIf.id_dst = 0;
    busIf.id_dst_wr = 0; busIf.id_is_load = 0; busIf.flush = 0; busIf.hold = 0;
    repeat (2) @(posedge clk);

    //                 name          v  rs rsU rt rtU dst wr ld fl hd rst  st A  B  cnt
    idle("reset_idle", 0);

    // ALU chain: add $3, then readers of $3 from EX, MEM and WR
    applyStimulus("alu_add3",   1,  0, 0,  0, 0,  3, 1, 0, 0, 0, 1,   0, 0, 0, 0);
    applyStimulus("alu_fwd_ex", 1,  3, 1,  0, 0,  4, 1, 0, 0, 0, 1,   0, 1, 0, 0);
    applyStimulus("alu_fwd_mem",1,  0, 0,  3, 1,  6, 1, 0, 0, 0, 1,   0, 0, 2, 0);
    applyStimulus("alu_fwd_wr", 1,  3, 1,  0, 0,  0, 0, 0, 0, 0, 1,   0, 3, 0, 0);
    applyStimulus("alu_retired",0,  3, 1,  0, 0,  0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    idle("drain_a", 0);
    idle("drain_b", 0);

    // Load-use: two stall cycles then forward from entry 2
    applyStimulus("lw5",        1,  0, 0,  0, 0,  5, 1, 1, 0, 0, 1,   0, 0, 0, 0);
    applyStimulus("lu_stall1",  1,  5, 1,  0, 0,  8, 1, 0, 0, 0, 1,   1, 1, 0, 0);
    applyStimulus("lu_stall2",  1,  5, 1,  0, 0,  8, 1, 0, 0, 0, 1,   1, 2, 0, 1);
    applyStimulus("lu_fwd",     1,  5, 1,  0, 0,  8, 1, 0, 0, 0, 1,   0, 3, 0, 2);
    idle("drain_c", 2);
    idle("drain_d", 2);
    idle("drain_e", 2);

    // Register zero never hazards; flush suppresses stall and inserts a bubble
    applyStimulus("lw0",        1,  0, 0,  0, 0,  0, 1, 1, 0, 0, 1,   0, 0, 0, 2);
    applyStimulus("read_r0",    1,  0, 1,  0, 1,  9, 1, 0, 0, 0, 1,   0, 0, 0, 2);
    applyStimulus("lw10",       1,  0, 0,  0, 0, 10, 1, 1, 0, 0, 1,   0, 0, 0, 2);
    applyStimulus("flush_lu",   1, 10, 1,  9, 1, 12, 1, 0, 1, 0, 1,   0, 1, 2, 2);
    applyStimulus("flush_bubble",1, 0, 0, 12, 1,  0, 0, 0, 0, 0, 1,   0, 0, 0, 2);
    idle("drain_f", 2);
    idle("drain_g", 2);
    idle("drain_h", 2);

    // Hold during load-use stall freezes board and counter
    applyStimulus("lw13",       1,  0, 0,  0, 0, 13, 1, 1, 0, 0, 1,   0, 0, 0, 2);
    applyStimulus("hold1",      1, 13, 1,  0, 0,  0, 0, 0, 0, 1, 1,   1, 1, 0, 2);
    applyStimulus("hold2",      1, 13, 1,  0, 0,  0, 0, 0, 0, 1, 1,   1, 1, 0, 2);
    applyStimulus("hold3",      1, 13, 1,  0, 0,  0, 0, 0, 0, 1, 1,   1, 1, 0, 2);
    applyStimulus("hold_rel1",  1, 13, 1,  0, 0,  0, 0, 0, 0, 0, 1,   1, 1, 0, 2);
    applyStimulus("hold_rel2",  1, 13, 1,  0, 0,  0, 0, 0, 0, 0, 1,   1, 2, 0, 3);
    applyStimulus("hold_fwd",   1, 13, 1,  0, 0,  0, 0, 0, 0, 0, 1,   0, 3, 0, 4);
    idle("drain_i", 4);
    idle("drain_j", 4);
    idle("drain_k", 4);

    // Ten load-use pairs: 20 stall cycles saturate the 4-bit counter
    for (int k = 0; k < 10; k++) begin
      applyStimulus("sat_lw",   1,  0, 0,  0, 0, 15, 1, 1, 0, 0, 1,   0, 0, 0, sat(4 + 2*k));
      applyStimulus("sat_st1",  1, 15, 1,  0, 0,  0, 0, 0, 0, 0, 1,   1, 1, 0, sat(4 + 2*k));
      applyStimulus("sat_st2",  1, 15, 1,  0, 0,  0, 0, 0, 0, 0, 1,   1, 2, 0, sat(5 + 2*k));
      applyStimulus("sat_fwd",  1, 15, 1,  0, 0,  0, 0, 0, 0, 0, 1,   0, 3, 0, sat(6 + 2*k));
    end
    idle("sat_final", 15);

    // Youngest match wins; an older ready producer cannot hide a young load
    applyStimulus("y_add7a",    1,  0, 0,  0, 0,  7, 1, 0, 0, 0, 1,   0, 0, 0, 15);
    applyStimulus("y_mid20",    1,  0, 0,  0, 0, 20, 1, 0, 0, 0, 1,   0, 0, 0, 15);
    applyStimulus("y_add7b",    1,  0, 0,  0, 0,  7, 1, 0, 0, 0, 1,   0, 0, 0, 15);
    applyStimulus("y_read7",    1,  7, 1,  0, 0,  0, 0, 0, 0, 0, 1,   0, 1, 0, 15);
    applyStimulus("y_lw7",      1,  0, 0,  0, 0,  7, 1, 1, 0, 0, 1,   0, 0, 0, 15);
    applyStimulus("y_ld_st1",   1,  0, 0,  7, 1,  0, 0, 0, 0, 0, 1,   1, 0, 1, 15);
    applyStimulus("y_ld_st2",   1,  0, 0,  7, 1,  0, 0, 0, 0, 0, 1,   1, 0, 2, 15);
    applyStimulus("y_ld_fwd",   1,  0, 0,  7, 1,  0, 0, 0, 0, 0, 1,   0, 0, 3, 15);

    // Asynchronous reset with the board full of loads
    applyStimulus("r_lw5",      1,  0, 0,  0, 0,  5, 1, 1, 0, 0, 1,   0, 0, 0, 15);
    applyStimulus("r_lw6",      1,  0, 0,  0, 0,  6, 1, 1, 0, 0, 1,   0, 0, 0, 15);
    applyStimulus("r_lw7",      1,  0, 0,  0, 0,  7, 1, 1, 0, 0, 1,   0, 0, 0, 15);
    applyStimulus("r_full",     1,  7, 1,  6, 1,  0, 0, 0, 0, 0, 1,   1, 1, 2, 15);
    applyStimulus("r_assert",   1,  7, 1,  6, 1,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    applyStimulus("r_release",  1,  7, 1,  6, 1,  0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    idle("r_idle", 0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised interlock and forwarding controller for the pipelined MIPS core; successor to the fixed single-stage hazard stall.
- Holds a shadow scoreboard of destination registers for DEPTH pipeline stages downstream of ID (EX, MEM, WR by default).
- From the scoreboard it produces a load-use stall, per-operand forwarding selects and a stall-cycle performance counter.
- Sits beside the IF/ID register; its stall drives the IFU/IF-ID hold and its selects drive the ALU operand muxes.

Parameters:
DEPTH, 3, number of tracked stages after ID (entry 0 = EX, entry DEPTH-1 = WR)
AW, 5, register address width
LOAD_READY, 2, first entry index whose load result is forwardable (2 = after MEM)
CNT_W, 16, stall counter width
SEL_W, 2, forwarding select width; must satisfy 2^SEL_W >= DEPTH+1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  AW  source A address
id_rt  in  AW  source B address
id_rs_used  in  1  instruction reads rs
id_rt_used  in  1  instruction reads rt
id_dst  in  AW  destination address (rd, rt or 31, already resolved)
id_dst_wr  in  1  instruction writes a register
id_is_load  in  1  instruction is lw/lh/lb family
flush  in  1  branch/jump taken; ID instruction is squashed
hold  in  1  global pipeline freeze (e.g. dm wait)
stall  out  1  freeze PC and IF/ID, insert bubble into EX
fwd_a_sel  out  SEL_W  0 = regFile BusA; k = forward from entry k-1
fwd_b_sel  out  SEL_W  same for BusB
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard entry e[i], i=0..DEPTH-1, holds {v, dst, wr, ld}.
- Reset (reset=0, async): all v=0 and stall_cnt=0. Because the outputs are combinational from an empty board, stall=0 and fwd_*_sel=0 during and after reset. Reset mid-operation discards every in-flight entry.
- match(i,r): e[i].v & e[i].wr & e[i].dst==r & r!=0. Register 0 never causes a hazard or a forward.
- notready(i): e[i].ld & (i < LOAD_READY).
- hazard: (id_rs_used & some i with match(i,id_rs) & notready(i)), or the same condition for id_rt.
- Only the youngest match (lowest i) is considered. An older ready producer never hides a younger not-ready one.
- stall = id_valid & ~flush & hazard. Flush dominates stall.
- fwd_a_sel = 1 + (lowest i with match(i,id_rs) & id_rs_used), else 0. fwd_b_sel is the same for id_rt.
- Selects are valid only when stall=0; during a stall they still show the youngest match.
- Sequential update at posedge clk when reset=1:
  - hold=1: no scoreboard change; stall_cnt unchanged.
  - hold=0: e[i] <= e[i-1] for i>=1. The oldest entry drops out of the board.
  - e[0] <= bubble (v=0) if stall | flush | ~id_valid; otherwise {1, id_dst, id_dst_wr, id_is_load}.
  - stall_cnt increments when stall=1 and hold=0, saturating at all-ones (no wrap).
- Latency: load followed immediately by a dependent instruction gives stall=1 for LOAD_READY-0 = 2 cycles (default), then forwards from entry LOAD_READY.
- An ALU producer one instruction ahead needs no stall; fwd selects entry 0.
- A producer in the WR entry is forwarded, so the regFile write-then-read ordering does not matter.
- Simultaneous flush and hold: hold wins; nothing shifts and the flush is re-presented by the control logic.

Test Plan:
1. Reset: drive reset=0 mid-stream with the board full of loads → stall=0, fwd_a_sel=0 and fwd_b_sel=0 immediately; stall_cnt=0.
2. ALU chain: add $3 (dst 3), next cycle sub reading rs=3 → stall=0, fwd_a_sel=1. One cycle later a third instruction reading rt=3 → fwd_b_sel=2.
3. Load-use: lw dst=5, next instruction reads rs=5 → stall=1 for 2 cycles, then fwd_a_sel=3. stall_cnt advances by 2.
4. Register zero and flush:
   - Load writing dst=0 followed by a reader of $0 → stall=0, sel=0.
   - Load-use hazard with flush=1 → stall=0 and a bubble enters e[0].
5. Hold: during a load-use stall assert hold=1 for 3 cycles → stall stays 1, scoreboard frozen, stall_cnt unchanged. Release hold → 2 more stall cycles.
6. Saturation and youngest-match: with CNT_W=4, force 20 stall cycles → stall_cnt=15. Two in-flight writers of $7 (entries 0 and 2) → fwd_a_sel=1.
